// File: rtl/echo_core_if.sv
// Sample bus between the codec interface and the echo core.
// VALID is a one-clock pulse with no ready: a pulse that arrives while the core is busy is dropped.
interface echo_core_if;
    logic        VALID;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic [15:0] left_out;
    logic [15:0] right_out;

    modport master (output VALID, left_in, right_in, input left_out, right_out);
    modport slave  (input VALID, left_in, right_in, output left_out, right_out);
endinterface

// File: rtl/echo_core.sv
// Stereo feedback echo: out = sat(in + (out delayed by DELAY samples >>> (atten+1))).
// One sample pair is processed per VALID through IDLE -> RD -> MIX -> WR.
module echo_core #(
    parameter int DELAY  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    echo_core_if.slave  bus,
    input  logic        bypass,
    input  logic [1:0]  atten,
    output logic        busy,
    output logic        overrun,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MIX  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   wptr;
    logic                primed;
    logic [15:0]         hold_l, hold_r;
    logic                hold_byp;
    logic [1:0]          hold_att;
    logic [15:0]         out_l, out_r;
    logic [31:0]         rdata;
    logic [31:0]         mem [DELAY];
    logic                rd_en, wr_en;
    logic [15:0]         mix_l, mix_r;
    logic [31:0]         delayed;
    logic [2:0]          shift;

    function automatic logic [15:0] mix(input logic [15:0] x, input logic [15:0] d,
                                        input logic [2:0] sh);
        logic signed [15:0] ds;
        logic signed [16:0] s;
        ds = $signed(d) >>> sh;
        s  = $signed({x[15], x}) + $signed({ds[15], ds});
        // Overflow shows up as the two top bits disagreeing.
        if (s[16] != s[15])
            mix = s[16] ? 16'h8000 : 16'h7FFF;
        else
            mix = s[15:0];
    endfunction

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: if (bus.VALID) begin
                state_next = RD;
                rd_en      = 1'b1;
            end
            RD:   state_next = MIX;
            MIX:  state_next = WR;
            WR: begin
                state_next = IDLE;
                wr_en      = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Unwritten RAM is never trusted: history reads as silence until the first wrap.
    always_comb begin
        delayed = primed ? rdata : 32'd0;
        shift   = {1'b0, hold_att} + 3'd1;
        mix_l   = hold_byp ? hold_l : mix(hold_l, delayed[31:16], shift);
        mix_r   = hold_byp ? hold_r : mix(hold_r, delayed[15:0], shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wptr     <= '0;
            primed   <= 1'b0;
            hold_l   <= '0;
            hold_r   <= '0;
            hold_byp <= 1'b0;
            hold_att <= '0;
            out_l    <= '0;
            out_r    <= '0;
            overrun  <= 1'b0;
        end else begin
            state <= state_next;
            if (bus.VALID && state != IDLE)
                overrun <= 1'b1;
            if (state == IDLE && bus.VALID) begin
                hold_l   <= bus.left_in;
                hold_r   <= bus.right_in;
                hold_byp <= bypass;
                hold_att <= atten;
            end
            if (state == MIX) begin
                out_l <= mix_l;
                out_r <= mix_r;
            end
            if (state == WR) begin
                if (wptr == ADDR_W'(DELAY - 1)) begin
                    wptr   <= '0;
                    primed <= 1'b1;
                end else begin
                    wptr <= wptr + 1'b1;
                end
            end
        end
    end

    // The stored word is the registered result, so the echo feeds back on itself.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= {out_l, out_r};
        if (rd_en)
            rdata <= mem[wptr];
    end

    assign bus.left_out  = out_l;
    assign bus.right_out = out_r;
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

endmodule

// File: tb/tb_echo_core.sv
// Bench for echo_core: directed samples, a history-based echo model and a per-cycle compare process.
module tb_echo_core;
    localparam int DELAY  = 4;
    localparam int ADDR_W = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bypass = 1'b0;
    logic [1:0] atten = 2'd0;
    logic       busy, overrun;
    logic [1:0] state_dbg;

    echo_core_if bus ();

    echo_core #(.DELAY(DELAY), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .bypass(bypass), .atten(atten),
        .busy(busy), .overrun(overrun), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_l = 0, exp_r = 0;
    bit exp_busy = 1'b0, exp_ovr = 1'b0, chk_en = 1'b0;
    int hist_l[$], hist_r[$];

    function automatic int sat16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Output for one sample given the output DELAY samples back (valid only once history exists).
    function automatic int model_out(int x, int past, bit have, bit byp, int att);
        if (byp) return x;
        return sat16(x + (have ? (past >>> (att + 1)) : 0));
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("left_out", int'($signed(bus.left_out)), exp_l);
            check("right_out", int'($signed(bus.right_out)), exp_r);
            check("busy", int'(busy), int'(exp_busy));
            check("overrun", int'(overrun), int'(exp_ovr));
        end
    end

    task automatic do_reset();
        chk_en    = 1'b0;
        bus.VALID = 1'b0;
        rst_n     = 1'b0;
        hist_l.delete();
        hist_r.delete();
        exp_l = 0; exp_r = 0; exp_busy = 1'b0; exp_ovr = 1'b0;
        #1;
        check("rst_left", int'($signed(bus.left_out)), 0);
        check("rst_right", int'($signed(bus.right_out)), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    // extra[k] re-pulses VALID k cycles after the accepted pulse (k = 1..3).
    task automatic send(int l, int r, bit byp, int att, logic [3:0] extra);
        int n, rl, rr;
        bit pend;
        @(posedge clk);
        #1;
        bus.VALID    = 1'b1;
        bus.left_in  = l[15:0];
        bus.right_in = r[15:0];
        bypass       = byp;
        atten        = att[1:0];
        n  = hist_l.size();
        rl = model_out(l, (n >= DELAY) ? hist_l[n - DELAY] : 0, n >= DELAY, byp, att);
        rr = model_out(r, (n >= DELAY) ? hist_r[n - DELAY] : 0, n >= DELAY, byp, att);
        hist_l.push_back(rl);
        hist_r.push_back(rr);
        pend = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            if (pend) exp_ovr = 1'b1;
            bus.VALID = extra[k];
            pend      = extra[k];
            exp_busy  = 1'b1;
            // Controls flip mid-sample; the held copies must still govern this sample.
            if (k == 1) begin
                bypass = ~byp;
                atten  = ~att[1:0];
            end
            if (k == 3) begin
                exp_l = rl;
                exp_r = rr;
            end
        end
        @(posedge clk);
        #1;
        if (pend) exp_ovr = 1'b1;
        bus.VALID = 1'b0;
        exp_busy  = 1'b0;
    endtask

    int t2_exp[13] = '{16000, 0, 0, 0, 8000, 0, 0, 0, 4000, 0, 0, 0, 2000};

    initial begin
        bus.VALID = 1'b0;
        bus.left_in = '0;
        bus.right_in = '0;

        // 1: single sample, 3-cycle latency
        do_reset();
        send(1000, -1000, 1'b0, 0, 4'b0000);
        check("t1_left", int'($signed(bus.left_out)), 1000);
        check("t1_right", int'($signed(bus.right_out)), -1000);

        // 2: impulse response with feedback decay
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 16000 : 0, (i == 0) ? 16000 : 0, 1'b0, 0, 4'b0000);
            check($sformatf("t2_left_%0d", i), int'($signed(bus.left_out)), t2_exp[i]);
            check($sformatf("t2_right_%0d", i), int'($signed(bus.right_out)), t2_exp[i]);
        end

        // 3: saturation in both directions
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(32767, 32767, 1'b0, 0, 4'b0000);
            check("t3_pos", int'($signed(bus.left_out)), 32767);
        end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(-32768, -32768, 1'b0, 0, 4'b0000);
            check("t3_neg", int'($signed(bus.right_out)), -32768);
        end

        // 4: pulses at +1 and +3 (the WR->IDLE cycle) are dropped and flagged
        do_reset();
        send(1234, -4321, 1'b0, 2, 4'b1010);
        check("t4_left", int'($signed(bus.left_out)), 1234);
        check("t4_overrun", int'(overrun), 1);
        send(200, 300, 1'b0, 1, 4'b0000);
        check("t4_next_left", int'($signed(bus.left_out)), 200);

        // 5: bypass impulse, then echoes resume from the raw history
        do_reset();
        send(16000, -16000, 1'b1, 0, 4'b0000);
        check("t5_byp_left", int'($signed(bus.left_out)), 16000);
        for (int i = 1; i < 6; i++) send(0, 0, 1'b0, 0, 4'b0000);
        check("t5_echo_left", hist_l[4], 8000);
        check("t5_echo_right", hist_r[4], -8000);
        // Mixed attenuation with negative samples on a primed line
        send(-300, 300, 1'b0, 3, 4'b0000);
        send(-7, 7, 1'b0, 1, 4'b0000);

        // 6: reset during RD, then fresh history
        @(posedge clk);
        #1;
        bus.VALID = 1'b1;
        bus.left_in = 16'd500;
        bus.right_in = 16'd500;
        @(posedge clk);
        #1;
        bus.VALID = 1'b0;
        chk_en = 1'b0;
        check("t6_busy_in_rd", int'(busy), 1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(100, 100, 1'b0, 0, 4'b0000);
            // The fifth sample echoes the first post-reset sample, not stale RAM.
            check($sformatf("t6_left_%0d", i), int'($signed(bus.left_out)), (i < 4) ? 100 : 150);
        end

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
